retire_buffer: RTL and testbench

Output-side buffer that sits directly downstream of the global-stall pipeline and captures its address/ID/valid stream. Queues completed requests for a ready/valid consumer and drives the pipeline's global stall when it runs out of room. Invalidates queued entries whose ID matches a flush, so flushed requests that were already in the buffer are never retired.

---
 rtl/retire_buffer.sv | 115 +++++++++++
 tb/tb_retire_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_buffer.sv
// Retire buffer: queues completed pipeline requests for a ready/valid consumer, drives the
// pipeline's registered global stall near full, and kills queued entries matching a flush ID.
// Optional RETIRE_DROP_COUNT_EN adds a saturating drop_count of entries discarded as not live.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module retire_buffer #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`ADDRESS_WIDTH-1:0] in_address,
    input  logic [`ID_WIDTH-1:0]      in_id,
    input  logic                      in_valid,
    input  logic                      in_flush,
    input  logic [`ID_WIDTH-1:0]      in_flush_id,
    output logic [`ADDRESS_WIDTH-1:0] out_address,
    output logic [`ID_WIDTH-1:0]      out_id,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_stall,
    output logic [$clog2(DEPTH):0]    count
`ifdef RETIRE_DROP_COUNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] THRESH  = CW'(DEPTH - STALL_MARGIN);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [`ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [`ID_WIDTH-1:0]      id_q   [DEPTH];
    logic [DEPTH-1:0]          live_q, live_d;
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      stall_q, stall_d;
    logic [PW-1:0]             occ_idx;

    logic push, pop, head_killed, head_flushed, head_live;

    assign push         = in_valid && !stall_q;
    assign head_killed  = (count_q != '0) && !live_q[rd_ptr_q];
    assign head_flushed = in_flush && (id_q[rd_ptr_q] == in_flush_id);
    assign head_live    = (count_q != '0) && live_q[rd_ptr_q] && !head_flushed;
    assign pop          = (head_live && out_ready) || head_killed;

    assign count_d = count_q + CW'(push) - CW'(pop);
    assign stall_d = (count_d >= THRESH);

    // A slot is occupied when its distance past rd_ptr is below count.
    always_comb begin
        live_d  = live_q;
        occ_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_idx = PW'(i) - rd_ptr_q;
            if (in_flush && ({1'b0, occ_idx} < count_q) && (id_q[i] == in_flush_id))
                live_d[i] = 1'b0;
        end
        if (push)
            live_d[wr_ptr_q] = !(in_flush && (in_id == in_flush_id));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                id_q[i]   <= '0;
            end
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= in_address;
                id_q[wr_ptr_q]   <= in_id;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            live_q  <= live_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

`ifdef RETIRE_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (reset)
            drop_q <= '0;
        else if (head_killed && (drop_q != 16'hFFFF))
            drop_q <= drop_q + 16'd1;
    end

    assign drop_count = drop_q;
`endif

    assign out_address = addr_q[rd_ptr_q];
    assign out_id      = id_q[rd_ptr_q];
    assign out_valid   = head_live;
    assign out_stall   = stall_q;
    assign count       = count_q;

endmodule

// File: tb/tb_retire_buffer.sv
// Directed bench for retire_buffer: three instances (STALL_MARGIN 0/2/3) share one stimulus.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_retire_buffer;

    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] in_address;
    logic [IW-1:0] in_id;
    logic          in_valid;
    logic          in_flush;
    logic [IW-1:0] in_flush_id;
    logic          out_ready;

    logic [AW-1:0] a0, a2, a3;
    logic [IW-1:0] i0, i2, i3;
    logic          v0, v2, v3;
    logic          s0, s2, s3;
    logic [3:0]    c0, c2, c3;
`ifdef RETIRE_DROP_COUNT_EN
    logic [15:0]   d0, d2, d3;
`endif

    always #5 clk = ~clk;

    retire_buffer #(.DEPTH(8), .STALL_MARGIN(0)) u0 (
        .clk(clk), .reset(reset), .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .in_flush(in_flush), .in_flush_id(in_flush_id), .out_address(a0), .out_id(i0),
        .out_valid(v0), .out_ready(out_ready), .out_stall(s0), .count(c0)
`ifdef RETIRE_DROP_COUNT_EN
        , .drop_count(d0)
`endif
    );

    retire_buffer #(.DEPTH(8), .STALL_MARGIN(2)) u2 (
        .clk(clk), .reset(reset), .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .in_flush(in_flush), .in_flush_id(in_flush_id), .out_address(a2), .out_id(i2),
        .out_valid(v2), .out_ready(out_ready), .out_stall(s2), .count(c2)
`ifdef RETIRE_DROP_COUNT_EN
        , .drop_count(d2)
`endif
    );

    retire_buffer #(.DEPTH(8), .STALL_MARGIN(3)) u3 (
        .clk(clk), .reset(reset), .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .in_flush(in_flush), .in_flush_id(in_flush_id), .out_address(a3), .out_id(i3),
        .out_valid(v3), .out_ready(out_ready), .out_stall(s3), .count(c3)
`ifdef RETIRE_DROP_COUNT_EN
        , .drop_count(d3)
`endif
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [IW-1:0] id;
        logic          fl;
        logic [IW-1:0] fid;
        logic          rdy;
        logic          ev;
        logic [IW-1:0] eid;
        logic [AW-1:0] ea;
        logic [3:0]    ec;
        logic          es;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic v, input int a, input int id, input logic fl,
                                input int fid, input logic rdy, input logic ev, input int eid,
                                input int ea, input int ec, input logic es);
        vec_t r;
        r.v = v; r.a = AW'(a); r.id = IW'(id); r.fl = fl; r.fid = IW'(fid); r.rdy = rdy;
        r.ev = ev; r.eid = IW'(eid); r.ea = AW'(ea); r.ec = 4'(ec); r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int id, input logic fl,
                         input int fid, input logic rdy);
        in_valid    = v;
        in_address  = AW'(a);
        in_id       = IW'(id);
        in_flush    = fl;
        in_flush_id = IW'(fid);
        out_ready   = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic flow: IDs 1..4 straight through, one cycle after push
        vecs.push_back(mk(1, 'h10, 1, 0, 0, 1,  0, 0, 0,     0, 0));
        vecs.push_back(mk(1, 'h11, 2, 0, 0, 1,  1, 1, 'h10,  1, 0));
        vecs.push_back(mk(1, 'h12, 3, 0, 0, 1,  1, 2, 'h11,  1, 0));
        vecs.push_back(mk(1, 'h13, 4, 0, 0, 1,  1, 3, 'h12,  1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  1, 4, 'h13,  1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     0, 0));
        // Queue {3,5,3,7}, flush 3: consumer sees 5 then 7 (pointers wrap here)
        vecs.push_back(mk(1, 'h20, 3, 0, 0, 0,  0, 0, 0,     0, 0));
        vecs.push_back(mk(1, 'h21, 5, 0, 0, 0,  1, 3, 'h20,  1, 0));
        vecs.push_back(mk(1, 'h22, 3, 0, 0, 0,  1, 3, 'h20,  2, 0));
        vecs.push_back(mk(1, 'h23, 7, 0, 0, 0,  1, 3, 'h20,  3, 0));
        vecs.push_back(mk(0, 0,    0, 1, 3, 1,  0, 0, 0,     4, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     4, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  1, 5, 'h21,  3, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     2, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  1, 7, 'h23,  1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     0, 0));
        // Same-cycle flush at head with out_ready: 5 never retired, 6 follows
        vecs.push_back(mk(1, 'h30, 5, 0, 0, 0,  0, 0, 0,     0, 0));
        vecs.push_back(mk(1, 'h31, 6, 0, 0, 0,  1, 5, 'h30,  1, 0));
        vecs.push_back(mk(0, 0,    0, 1, 5, 1,  0, 0, 0,     2, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     2, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  1, 6, 'h31,  1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     0, 0));
        // Push whose own ID matches the flush enters dead
        vecs.push_back(mk(1, 'h40, 9, 1, 9, 1,  0, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     1, 0));
        vecs.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0, 0,     0, 0));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(c0), 0);
        chk("rst_stall", 32'(s0), 0);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_addr",  32'(a0), 0);
        chk("rst_id",    32'(i0), 0);
        next_cycle();

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, int'(vecs[k].a), int'(vecs[k].id), vecs[k].fl,
                  int'(vecs[k].fid), vecs[k].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_valid", k), 32'(v0), 32'(vecs[k].ev));
            chk($sformatf("v%0d_count", k), 32'(c0), 32'(vecs[k].ec));
            chk($sformatf("v%0d_stall", k), 32'(s0), 32'(vecs[k].es));
            if (vecs[k].ev) begin
                chk($sformatf("v%0d_id", k),   32'(i0), 32'(vecs[k].eid));
                chk($sformatf("v%0d_addr", k), 32'(a0), 32'(vecs[k].ea));
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0);
`ifdef RETIRE_DROP_COUNT_EN
        @(negedge clk);
        chk("drop_count", 32'(d0), 4);
        next_cycle();
`endif

        // Fill with out_ready low: 10 offered pushes, each instance saturates at its threshold
        for (int k = 0; k < 10; k++) begin
            drive(1, 'h100 + k, 'h40 + k, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("fill%0d_c0", k), 32'(c0), 32'((k < 8) ? k : 8));
            chk($sformatf("fill%0d_s0", k), 32'(s0), 32'(k >= 8));
            chk($sformatf("fill%0d_c2", k), 32'(c2), 32'((k < 6) ? k : 6));
            chk($sformatf("fill%0d_s2", k), 32'(s2), 32'(k >= 6));
            chk($sformatf("fill%0d_s3", k), 32'(s3), 32'(k >= 5));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("full_c0", 32'(c0), 8);
        chk("full_s0", 32'(s0), 1);
        chk("full_c3", 32'(c3), 5);
        chk("full_v0", 32'(v0), 1);
        chk("full_id0", 32'(i0), 'h40);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pop_c0", 32'(c0), 7);
        chk("pop_s0", 32'(s0), 0);
        chk("pop_id0", 32'(i0), 'h41);
        chk("pop_c2", 32'(c2), 5);
        chk("pop_s2", 32'(s2), 0);
        next_cycle();

        // Refill one to re-stall, then reset mid-fill
        drive(1, 'h200, 'h50, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("refill_c0", 32'(c0), 8);
        chk("refill_s0", 32'(s0), 1);
        chk("refill_c3", 32'(c3), 5);
        chk("refill_s3", 32'(s3), 1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_c3", 32'(c3), 0);
        chk("mrst_s3", 32'(s3), 0);
        chk("mrst_v3", 32'(v3), 0);
        chk("mrst_s0", 32'(s0), 0);
        chk("mrst_id3", 32'(i3), 0);
        next_cycle();
        drive(1, 'h55, 'h77, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post_v3", 32'(v3), 1);
        chk("post_id3", 32'(i3), 'h77);
        chk("post_addr3", 32'(a3), 'h55);
        chk("post_c3", 32'(c3), 1);
        next_cycle();
        @(negedge clk);
        chk("post_empty_c3", 32'(c3), 0);
        chk("post_empty_v2", 32'(v2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
